cmd_tx: RTL

- SD command-line serializer for the cmd_driver.
- Latches a 6-bit command index and a 32-bit argument, then emits a 48-bit SD command frame MSB-first on the CMD line: start bit, transmission bit, index, argument, CRC7, end bit.
- Sits directly upstream of crc7, which it instantiates. crc7 consumes the 40 message bits and supplies the 7 checksum bits in unload mode.
- Enforces the NCC inter-command gap before accepting the next command.

---
 rtl/sd_cmd_pkg.sv | 20 ++
 rtl/crc7.sv | 27 ++
 rtl/cmd_tx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command path (transmitter now, response receiver later).
package sd_cmd_pkg;

  localparam int MSG_LEN   = 40;
  localparam int CRC_LEN   = 7;
  localparam int FRAME_LEN = 48;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MSG  = 3'd1,
    CRC  = 3'd2,
    STOP = 3'd3,
    GAP  = 3'd4
  } cmd_state_t;

endpackage

// File: rtl/crc7.sv
// Serial CRC7 (x^7 + x^3 + 1). Absorbs idata each cycle; in unload mode shifts
// the remainder out MSB first on ocrc.
module crc7 (
  input  logic iclk,
  input  logic irst,
  input  logic idata,
  input  logic iunload,
  output logic ocrc
);

  logic [6:0] crc_reg;
  logic       fb;

  assign fb   = idata ^ crc_reg[6];
  assign ocrc = crc_reg[6];

  always_ff @(posedge iclk) begin
    if (irst) begin
      crc_reg <= 7'd0;
    end else if (iunload) begin
      crc_reg <= {crc_reg[5:0], 1'b0};
    end else begin
      crc_reg <= {crc_reg[5:3], crc_reg[2] ^ fb, crc_reg[1:0], fb};
    end
  end

endmodule

// File: rtl/cmd_tx.sv
// SD CMD-line serializer: start, transmission bit, index, argument, CRC7, end bit,
// followed by an NCC-cycle idle gap before the next command can be accepted.
module cmd_tx
  import sd_cmd_pkg::*;
#(
  parameter int NCC = 8
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  input  logic [5:0]  iindex,
  input  logic [31:0] iarg,
  output logic        ocmd,
  output logic        ocmd_oe,
  output logic        obusy,
  output logic        odone
);

  localparam logic [5:0] LAST_MSG_CNT = 6'(MSG_LEN - 2);
  localparam logic [5:0] LAST_CRC_CNT = 6'(MSG_LEN + CRC_LEN - 2);
  localparam logic [5:0] END_CNT      = 6'(FRAME_LEN - 1);
  localparam logic [7:0] NCC_LOAD     = 8'(NCC);

  cmd_state_t         state_reg;
  logic [MSG_LEN-1:0] shift_reg;
  logic [5:0]         bit_cnt_reg;
  logic [7:0]         gap_cnt_reg;
  logic               cmd_reg;
  logic               oe_reg;
  logic               busy_reg;
  logic               done_reg;

  logic accept;
  logic crc_rst;
  logic crc_unload;
  logic crc_bit;

  assign accept     = (state_reg == IDLE) && istart;
  assign crc_rst    = irst | accept;
  assign crc_unload = (state_reg == CRC);

  // The start bit is zero, so clearing the CRC on the accept edge is the same as absorbing it.
  crc7 u_crc7 (
    .iclk    (iclk),
    .irst    (crc_rst),
    .idata   (shift_reg[MSG_LEN-1]),
    .iunload (crc_unload),
    .ocrc    (crc_bit)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= 6'd0;
      gap_cnt_reg <= 8'd0;
      cmd_reg     <= 1'b1;
      oe_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (istart) begin
            // Start bit goes straight to the line; the register holds bits 1..39 MSB-aligned.
            shift_reg   <= {TX_BIT, iindex, iarg, 1'b0};
            bit_cnt_reg <= 6'd0;
            cmd_reg     <= START_BIT;
            oe_reg      <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= MSG;
          end
        end
        MSG: begin
          cmd_reg     <= shift_reg[MSG_LEN-1];
          shift_reg   <= {shift_reg[MSG_LEN-2:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + 6'd1;
          if (bit_cnt_reg == LAST_MSG_CNT) begin
            state_reg <= CRC;
          end
        end
        CRC: begin
          cmd_reg     <= crc_bit;
          bit_cnt_reg <= bit_cnt_reg + 6'd1;
          if (bit_cnt_reg == LAST_CRC_CNT) begin
            state_reg <= STOP;
          end
        end
        STOP: begin
          if (bit_cnt_reg == END_CNT) begin
            cmd_reg     <= 1'b1;
            oe_reg      <= 1'b0;
            done_reg    <= 1'b1;
            gap_cnt_reg <= NCC_LOAD;
            state_reg   <= GAP;
          end else begin
            cmd_reg     <= END_BIT;
            bit_cnt_reg <= bit_cnt_reg + 6'd1;
          end
        end
        GAP: begin
          gap_cnt_reg <= gap_cnt_reg - 8'd1;
          if (gap_cnt_reg == 8'd1) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ocmd    = cmd_reg;
  assign ocmd_oe = oe_reg;
  assign obusy   = busy_reg;
  assign odone   = done_reg;

endmodule
